// File: rtl/pwm_pkg.sv
// Shared widths and constants for the PWM output peripheral.
package pwm_pkg;

  localparam int PWM_CNT_W   = 8;
  localparam int NUM_OUTPUTS = 16;
  localparam int PRESCALE_W  = 12;

  localparam logic [PWM_CNT_W-1:0] DUTY_FULL_ON = 8'hFF;

  // Duty 255 is treated as fully on (256/256), so a full-on duty never
  // drops low for the cnt==255 slot of the period.
  function automatic logic pwm_compare(input logic [PWM_CNT_W-1:0] cnt,
                                       input logic [PWM_CNT_W-1:0] duty);
    return (duty == DUTY_FULL_ON) ? 1'b1 : (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaled 8-bit PWM timebase: one count every PRESCALE clk,
// with a boundary strobe on the last clk of each 256-count period.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int PRESCALE = 13
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [PWM_CNT_W-1:0] pwm_cnt_o,
  output logic                 tick_o,
  output logic                 boundary_o
);

  localparam logic [PRESCALE_W-1:0] PRESC_MAX = PRESCALE_W'(PRESCALE - 1);

  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [PWM_CNT_W-1:0]  cnt_q, cnt_d;
  logic                  tick;

  // Next-state for the prescaler and the period counter (8-bit wrap is natural).
  always_comb begin
    tick    = (presc_q == PRESC_MAX);
    presc_d = tick ? '0 : presc_q + {{(PRESCALE_W-1){1'b0}}, 1'b1};
    cnt_d   = tick ? cnt_q + {{(PWM_CNT_W-1){1'b0}}, 1'b1} : cnt_q;
  end

  // Timebase state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      cnt_q   <= '0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pwm_cnt_o  = cnt_q;
  assign tick_o     = tick;
  assign boundary_o = tick && (cnt_q == {PWM_CNT_W{1'b1}});

endmodule

// File: rtl/pwm_peripheral.sv
// 16-output static/PWM pad driver fed by the SPI register block.
// Duty is shadowed at the period boundary so every period is whole.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int PRESCALE = 13
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             en_reg_out_7_0,
  input  logic [7:0]             en_reg_out_15_8,
  input  logic [7:0]             en_reg_pwm_7_0,
  input  logic [7:0]             en_reg_pwm_15_8,
  input  logic [7:0]             pwm_duty_cycle,
  output logic [NUM_OUTPUTS-1:0] out,
  output logic                   period_start
);

  logic [PWM_CNT_W-1:0]   pwm_cnt;
  logic                   tick;
  logic                   boundary;
  logic                   shadow_ld;
  logic                   pwm_level;
  logic [NUM_OUTPUTS-1:0] en_out, en_pwm;
  logic [PWM_CNT_W-1:0]   duty_shadow_q, duty_shadow_d;
  logic [NUM_OUTPUTS-1:0] out_q, out_d;
  logic                   period_start_q;

  pwm_timebase #(.PRESCALE(PRESCALE)) u_timebase (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwm_cnt_o  (pwm_cnt),
    .tick_o     (tick),
    .boundary_o (boundary)
  );

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  // boundary only fires on a tick; qualifying with tick keeps the shadow
  // load tied to the prescaled edge even if the boundary decode changes.
  assign shadow_ld = boundary & tick;

  // Shadow load, shared compare and per-pin output mux.
  always_comb begin
    duty_shadow_d = shadow_ld ? pwm_duty_cycle : duty_shadow_q;
    pwm_level     = pwm_compare(pwm_cnt, duty_shadow_q);
    out_d         = '0;
    for (int i = 0; i < NUM_OUTPUTS; i++)
      out_d[i] = en_out[i] & (en_pwm[i] ? pwm_level : 1'b1);
  end

  // Registered pad drive, duty shadow and period-start pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_shadow_q  <= '0;
      out_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      duty_shadow_q  <= duty_shadow_d;
      out_q          <= out_d;
      period_start_q <= shadow_ld;
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral with PRESCALE=13 (3328 clk per period).
module tb_pwm_peripheral;

  localparam int PER = 3328;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] en_out = '0;
  logic [15:0] en_pwm = '0;
  logic [7:0]  duty = '0;
  logic [15:0] out;
  logic        period_start;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pwm_peripheral #(.PRESCALE(13)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_out[7:0]),
    .en_reg_out_15_8 (en_out[15:8]),
    .en_reg_pwm_7_0  (en_pwm[7:0]),
    .en_reg_pwm_15_8 (en_pwm[15:8]),
    .pwm_duty_cycle  (duty),
    .out             (out),
    .period_start    (period_start)
  );

  // Advance to the next negedge where period_start is high (bounded).
  task automatic wait_ps(output bit ok);
    int n;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 4000) begin
      @(negedge clk);
      n++;
      if (period_start) ok = 1'b1;
    end
  endtask

  // Sample one full period after a period_start negedge; optionally
  // rewrite duty at sample change_at (0 = no change).
  task automatic measure(input int change_at, input logic [7:0] nd,
                         output int hi, output int ps_cnt, output int other);
    hi = 0; ps_cnt = 0; other = 0;
    for (int i = 1; i <= PER; i++) begin
      @(negedge clk);
      if (i == change_at) duty = nd;
      if (out[0]) hi++;
      if (out[15:1] != 15'h0) other++;
      if (period_start) ps_cnt++;
    end
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0; en_out = 16'hFFFF; en_pwm = 16'h0000; duty = 8'h80;
    repeat (3) @(negedge clk);
    checks++; if (out !== 16'h0000) begin errors++; $display("FAIL reset_out: got %h expected 0000", out); end
    checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL reset_ps: got %b expected 0", period_start); end
    rst_n = 1'b1;
    checks++; if (out !== 16'h0000) begin errors++; $display("FAIL release_out: got %h expected 0000", out); end
    @(posedge clk); #1;
    checks++; if (out !== 16'hFFFF) begin errors++; $display("FAIL first_edge_out: got %h expected ffff", out); end
    n = 1;
    @(negedge clk);
    while (!period_start && n < 4000) begin @(negedge clk); n++; end
    checks++; if (n != PER) begin errors++; $display("FAIL first_ps: got %0d clk expected %0d", n, PER); end
    n = 0;
    do begin @(negedge clk); n++; end while (!period_start && n < 4000);
    checks++; if (n != PER) begin errors++; $display("FAIL ps_spacing: got %0d clk expected %0d", n, PER); end
  endtask

  task automatic test_pwm_50();
    bit ok; int hi, ps, oth;
    en_out = 16'h0001; en_pwm = 16'h0001; duty = 8'h80;
    wait_ps(ok);
    checks++; if (!ok) begin errors++; $display("FAIL pwm50_wait: got timeout expected period_start"); end
    for (int p = 0; p < 2; p++) begin
      measure(0, 8'h00, hi, ps, oth);
      checks++; if (hi != 1664) begin errors++; $display("FAIL pwm50_high p%0d: got %0d expected 1664", p, hi); end
      checks++; if (oth != 0) begin errors++; $display("FAIL pwm50_upper p%0d: got %0d nonzero samples expected 0", p, oth); end
      checks++; if (ps != 1 || period_start !== 1'b1) begin errors++; $display("FAIL pwm50_ps p%0d: got %0d pulses expected 1 at end", p, ps); end
    end
  endtask

  task automatic test_duty_corners();
    logic [7:0] dv [3];
    int         ex [3];
    bit ok; int hi, ps, oth;
    dv[0] = 8'h00; ex[0] = 0;
    dv[1] = 8'hFF; ex[1] = PER;
    dv[2] = 8'h01; ex[2] = 13;
    for (int k = 0; k < 3; k++) begin
      duty = dv[k];
      wait_ps(ok);
      checks++; if (!ok) begin errors++; $display("FAIL corner_wait d=%h: got timeout expected period_start", dv[k]); end
      measure(0, 8'h00, hi, ps, oth);
      checks++; if (hi != ex[k]) begin errors++; $display("FAIL corner_high d=%h: got %0d expected %0d", dv[k], hi, ex[k]); end
    end
  endtask

  task automatic test_duty_change();
    bit ok; int hi, ps, oth;
    duty = 8'h40;
    wait_ps(ok);
    checks++; if (!ok) begin errors++; $display("FAIL chg_wait: got timeout expected period_start"); end
    measure(1000, 8'hC0, hi, ps, oth);
    checks++; if (hi != 832) begin errors++; $display("FAIL chg_cur_high: got %0d expected 832", hi); end
    checks++; if (ps != 1 || period_start !== 1'b1) begin errors++; $display("FAIL chg_ps: got %0d pulses expected 1 at end", ps); end
    measure(0, 8'h00, hi, ps, oth);
    checks++; if (hi != 2496) begin errors++; $display("FAIL chg_next_high: got %0d expected 2496", hi); end
  endtask

  task automatic test_multi_bit();
    bit ok; int even_bad, odd_bad, hi;
    en_out = 16'hFFFF; en_pwm = 16'hAAAA; duty = 8'h40;
    wait_ps(ok);
    checks++; if (!ok) begin errors++; $display("FAIL multi_wait: got timeout expected period_start"); end
    even_bad = 0; odd_bad = 0; hi = 0;
    for (int i = 1; i <= PER; i++) begin
      @(negedge clk);
      if ((out & 16'h5555) != 16'h5555) even_bad++;
      if ((out & 16'hAAAA) != 16'h0000 && (out & 16'hAAAA) != 16'hAAAA) odd_bad++;
      if (out[1]) hi++;
    end
    checks++; if (even_bad != 0) begin errors++; $display("FAIL multi_even: got %0d bad samples expected 0", even_bad); end
    checks++; if (odd_bad != 0) begin errors++; $display("FAIL multi_odd_align: got %0d bad samples expected 0", odd_bad); end
    checks++; if (hi != 832) begin errors++; $display("FAIL multi_odd_high: got %0d expected 832", hi); end
    en_out = 16'h00FF;
    checks++; if ((out[15:8] & 8'h55) !== 8'h55) begin errors++; $display("FAIL multi_no_early: got %h expected even bits set", out[15:8]); end
    @(posedge clk); #1;
    checks++; if (out[15:8] !== 8'h00) begin errors++; $display("FAIL multi_disable: got %h expected 00", out[15:8]); end
    checks++; if ((out[7:0] & 8'h55) !== 8'h55) begin errors++; $display("FAIL multi_low_keep: got %h expected even bits set", out[7:0]); end
  endtask

  task automatic test_reset_mid();
    bit ok; int hi, ps, oth;
    en_out = 16'h0001; en_pwm = 16'h0001; duty = 8'h80;
    wait_ps(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_wait: got timeout expected period_start"); end
    repeat (500) @(negedge clk);
    checks++; if (out[0] !== 1'b1) begin errors++; $display("FAIL rmid_pre: got %b expected 1", out[0]); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out !== 16'h0000 || period_start !== 1'b0) begin errors++; $display("FAIL rmid_async: got out=%h ps=%b expected 0000/0", out, period_start); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hi = 0;
    for (int i = 1; i <= PER; i++) begin
      @(negedge clk);
      if (out[0]) hi++;
    end
    checks++; if (hi != 0) begin errors++; $display("FAIL rmid_first_period: got %0d high clk expected 0", hi); end
    checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL rmid_ps: got %b expected 1", period_start); end
    measure(0, 8'h00, hi, ps, oth);
    checks++; if (hi != 1664) begin errors++; $display("FAIL rmid_second_period: got %0d expected 1664", hi); end
  endtask

  initial begin
    test_reset();
    test_pwm_50();
    test_duty_corners();
    test_duty_change();
    test_multi_bit();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_peripheral.md
Name: pwm_peripheral

Overview:
- Consumes the five configuration registers written over SPI: en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8 and pwm_duty_cycle.
- Drives the 16 chip outputs, each either static or PWM-modulated.
- Contains a prescaled 8-bit timebase and a glitch-free duty shadow register.
- Sits directly downstream of the SPI register block; its outputs go straight to the pads.

Parameters:
- PRESCALE, 13: clk cycles per PWM count. Valid range 1..4095. 13 × 256 = 3328 clk per period, ≈3.005 kHz at 10 MHz.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- en_reg_out_7_0  input  8  output enable, bits 7:0
- en_reg_out_15_8  input  8  output enable, bits 15:8
- en_reg_pwm_7_0  input  8  PWM mode select, bits 7:0
- en_reg_pwm_15_8  input  8  PWM mode select, bits 15:8
- pwm_duty_cycle  input  8  requested duty, 0..255
- out  output  16  pad drive; bit i maps to enable/mode bit i
- period_start  output  1  one-clk pulse on the cycle pwm_cnt becomes 0

Behaviour:
- Reset, asynchronous: presc_cnt=0, pwm_cnt=0, duty_shadow=0, out=16'h0000, period_start=0.
- Prescaler:
  - presc_cnt counts 0..PRESCALE-1 and wraps.
  - tick=1 when presc_cnt==PRESCALE-1.
  - PRESCALE=1 gives tick every cycle.
- Counter:
  - pwm_cnt, 8-bit, increments on tick and wraps 255→0.
  - Period = 256 × PRESCALE clk.
- Boundary, defined as tick && pwm_cnt==255:
  - duty_shadow <= pwm_duty_cycle, sampled in that same cycle.
  - period_start=1 in the following cycle, aligned with pwm_cnt==0.
- Duty register behaviour:
  - A pwm_duty_cycle change mid-period has no effect until the next boundary. No runt or extended pulses.
  - If a change coincides with the boundary cycle, the new value is latched.
- PWM level, combinational:
  - pwm_level = (duty_shadow==8'hFF) ? 1 : (pwm_cnt < duty_shadow).
  - duty 0 gives a constant low output.
  - duty 255 gives a constant high output, 256/256.
  - Otherwise high for duty_shadow counts of each period.
- Output, registered, per bit i:
  - out[i] <= en_out[i] ? (en_pwm[i] ? pwm_level : 1) : 0.
  - en_out = {en_reg_out_15_8, en_reg_out_7_0}; en_pwm likewise.
  - en_pwm[i] is ignored when en_out[i]=0.
- Latency:
  - Enable or mode change appears on out exactly 1 clk later; no period alignment.
  - The pwm_level edge appears on out 1 clk after the pwm_cnt change.
- All PWM-mode bits share one pwm_level, so they are phase-aligned and toggle in the same cycle.
- Reset mid-operation: everything returns to reset values immediately. Counting restarts from 0 after rst_n deasserts. duty_shadow=0 until the first boundary, so PWM bits are low for the first period.
- Inputs are synchronous to clk (register-block outputs); no synchronisers.

Decomposition:
- Package pwm_pkg holds:
  - PWM_CNT_W=8
  - NUM_OUTPUTS=16
  - DUTY_FULL_ON=8'hFF
  - PRESCALE_W=12 (prescaler width)
- Sub-module pwm_timebase, parameter PRESCALE:
  - Contains the prescaler and pwm_cnt.
  - Outputs pwm_cnt, tick and boundary.
- Top level holds duty_shadow, the compare and the output mux/register.

Test Plan:
- Reset with en_out=16'hFFFF, en_pwm=0, duty=8'h80, then release rst_n → out=0 during reset; out=16'hFFFF exactly 1 clk after the first post-reset edge; period_start pulses every 3328 clk.
- en_out=16'h0001, en_pwm=16'h0001, duty=8'h80, wait 2 periods → out[0] high 128×13=1664 clk and low 1664 clk per period; out[15:1]=0.
- Duty corners: duty=0 → out[0] constant 0 over a full period; duty=8'hFF → constant 1; duty=1 → high exactly 13 clk per period.
- Change duty 8'h40→8'hC0 mid-period → current period keeps its 832-clk high time; next period, starting at period_start, is high 2496 clk.
- en_out=16'hFFFF, en_pwm=16'hAAAA, duty=8'h40 → even bits constant 1; odd bits PWM and toggling in the same cycle; clearing en_out[15:8] gives out[15:8]=0 after 1 clk.
- Assert rst_n mid-period with duty_shadow=8'h80 → out=0 immediately; after release, PWM bits stay low for the first 3328 clk, then run at 50%.
